// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with a prefetch FIFO between the PC and a variable-latency
// instruction memory; handles redirects by flushing the FIFO and dropping wrong-path responses.
module if_stage_prefetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INST_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        PCsrc,
  input  logic [ADDR_W-1:0] j_target,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [ADDR_W-1:0] ret_target,
  input  logic              stall,
  input  logic              kill,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] npc_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     tag_wr;
  logic [PW-1:0]     tag_rd;

  logic [INST_W-1:0] fifo_inst [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [ADDR_W-1:0] tag_mem   [DEPTH];

  logic              redirect;
  logic              accept;
  logic              resp_keep;
  logic              resp_drop;
  logic              pop;
  logic [ADDR_W-1:0] redirect_pc;
  logic [SW-1:0]     credits_used;

  // Redirect target selection
  always_comb begin
    redirect_pc = fetch_pc;
    case (PCsrc)
      2'd1:    redirect_pc = j_target;
      2'd2:    redirect_pc = i_target;
      2'd3:    redirect_pc = ret_target;
      default: redirect_pc = fetch_pc;
    endcase
  end

  // Every FIFO slot is pre-reserved by an in-flight request, so responses never overflow
  assign credits_used = SW'(count) + SW'(outstanding) + SW'(drop_cnt);
  assign redirect     = (PCsrc != 2'd0) && !stall;
  assign imem_req     = rst_n && !redirect && (credits_used < SW'(DEPTH));
  assign imem_addr    = fetch_pc;
  assign accept       = imem_req && imem_gnt;
  assign resp_drop    = imem_rvalid && (drop_cnt != '0);
  assign resp_keep    = imem_rvalid && (drop_cnt == '0) && !redirect;

  assign inst_valid   = (count != '0);
  assign pop          = inst_valid && !stall && !redirect;

  assign inst_out     = !inst_valid ? '0 : (kill ? NOP_INST : fifo_inst[rd_ptr]);
  assign pc_out       = inst_valid ? fifo_pc[rd_ptr] : '0;
  assign npc_out      = inst_valid ? fifo_pc[rd_ptr] + ADDR_W'(1) : '0;

  // PC, pointers and request accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (redirect)
        fetch_pc <= redirect_pc;
      else if (accept)
        fetch_pc <= fetch_pc + ADDR_W'(1);

      if (accept)      tag_wr <= tag_wr + PW'(1);
      if (imem_rvalid) tag_rd <= tag_rd + PW'(1);

      if (redirect) begin
        // A response landing now belongs to the old path: it retires one of the
        // already-dropped requests or one of the outstanding ones being converted.
        count       <= '0;
        rd_ptr      <= wr_ptr;
        outstanding <= '0;
        drop_cnt    <= drop_cnt + outstanding - CW'(imem_rvalid);
      end else begin
        if (resp_keep) wr_ptr <= wr_ptr + PW'(1);
        if (pop)       rd_ptr <= rd_ptr + PW'(1);
        count       <= count + CW'(resp_keep) - CW'(pop);
        outstanding <= outstanding + CW'(accept) - CW'(resp_keep);
        drop_cnt    <= drop_cnt - CW'(resp_drop);
      end
    end
  end

  // Address-tag queue and instruction FIFO storage
  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[tag_wr] <= fetch_pc;
    if (resp_keep) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= tag_mem[tag_rd];
    end
    if (rst_n)
      assert (!(resp_keep && (count == CW'(DEPTH))));
  end

endmodule
